// File: rtl/axis_fcs_insert.sv
// Byte-wide AXI-stream Ethernet FCS inserter: optional zero padding, then the inverted CRC32 LSB first.
// The lfsr module below is the combinational Galois next-state function it sequences.

module lfsr #(
   parameter int                    LFSR_WIDTH   = 32,
   parameter logic [LFSR_WIDTH-1:0] LFSR_POLY    = 32'h04c11db7,
   parameter bit                    REVERSE      = 1'b1,
   parameter bit                    FEED_FORWARD = 1'b0,
   parameter int                    DATA_WIDTH   = 8
) (
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic [LFSR_WIDTH-1:0] state_in,
   output logic [LFSR_WIDTH-1:0] state_out
);

   function automatic logic [LFSR_WIDTH-1:0] bit_rev(input logic [LFSR_WIDTH-1:0] v);
      for (int i = 0; i < LFSR_WIDTH; i++) bit_rev[i] = v[LFSR_WIDTH-1-i];
   endfunction

   // A reflected LFSR is the forward one run on the mirrored state with data taken LSB first.
   always_comb begin
      logic [LFSR_WIDTH-1:0] w_s;
      logic                  w_d;
      logic                  w_fb;
      w_s = REVERSE ? bit_rev(state_in) : state_in;
      for (int i = 0; i < DATA_WIDTH; i++) begin
         w_d  = REVERSE ? data_in[i] : data_in[DATA_WIDTH-1-i];
         w_fb = FEED_FORWARD ? w_s[LFSR_WIDTH-1] : (w_s[LFSR_WIDTH-1] ^ w_d);
         w_s  = {w_s[LFSR_WIDTH-2:0], 1'b0} ^ (w_fb ? LFSR_POLY : '0);
      end
      state_out = REVERSE ? bit_rev(w_s) : w_s;
   end

endmodule

module axis_fcs_insert #(
   parameter bit ENABLE_PADDING   = 1'b1,
   parameter int MIN_FRAME_LENGTH = 60
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] s_axis_tdata,
   input  logic       s_axis_tvalid,
   output logic       s_axis_tready,
   input  logic       s_axis_tlast,
   input  logic       s_axis_tuser,
   output logic [7:0] m_axis_tdata,
   output logic       m_axis_tvalid,
   input  logic       m_axis_tready,
   output logic       m_axis_tlast,
   output logic       m_axis_tuser
);

   localparam logic [8:0] MIN_LEN = 9'(MIN_FRAME_LENGTH);

   typedef enum logic [1:0] {ST_PAYLOAD, ST_PAD, ST_FCS} state_t;

   state_t      r_state, w_state_next;
   logic [31:0] r_crc, w_crc_next;
   logic [7:0]  r_count, w_count_next;
   logic        r_first, w_first_next;
   logic        r_user, w_user_next;
   logic [1:0]  r_fcs_idx, w_fcs_idx_next;
   logic [7:0]  r_m_tdata, w_m_tdata_next;
   logic        r_m_tvalid, w_m_tvalid_next;
   logic        r_m_tlast, w_m_tlast_next;
   logic        r_m_tuser, w_m_tuser_next;

   logic        w_load;
   logic        w_tready;
   logic [7:0]  w_lfsr_data;
   logic [31:0] w_crc_in;
   logic [31:0] w_crc_out;
   logic [31:0] w_fcs;
   logic [7:0]  w_fcs_byte;
   logic [8:0]  w_count_plus1;
   logic [7:0]  w_count_sat;

   assign w_load        = !r_m_tvalid || m_axis_tready;
   assign w_crc_in      = r_first ? 32'hffff_ffff : r_crc;
   assign w_fcs         = ~r_crc;
   assign w_count_plus1 = {1'b0, r_count} + 9'd1;
   assign w_count_sat   = (w_count_plus1 > MIN_LEN) ? r_count : w_count_plus1[7:0];

   lfsr #(
      .LFSR_WIDTH  (32),
      .LFSR_POLY   (32'h04c11db7),
      .REVERSE     (1'b1),
      .FEED_FORWARD(1'b0),
      .DATA_WIDTH  (8)
   ) u_crc (
      .data_in  (w_lfsr_data),
      .state_in (w_crc_in),
      .state_out(w_crc_out)
   );

   always_comb begin
      unique case (r_fcs_idx)
         2'd0:    w_fcs_byte = w_fcs[7:0];
         2'd1:    w_fcs_byte = w_fcs[15:8];
         2'd2:    w_fcs_byte = w_fcs[23:16];
         default: w_fcs_byte = w_fcs[31:24];
      endcase
   end

   // NOTE: every signal gets a default before the case so no path can leave one unassigned and infer a latch.
   always_comb begin
      w_state_next    = r_state;
      w_crc_next      = r_crc;
      w_count_next    = r_count;
      w_first_next    = r_first;
      w_user_next     = r_user;
      w_fcs_idx_next  = r_fcs_idx;
      w_m_tdata_next  = r_m_tdata;
      w_m_tvalid_next = r_m_tvalid && !w_load;
      w_m_tlast_next  = r_m_tlast;
      w_m_tuser_next  = r_m_tuser;
      w_tready        = 1'b0;
      w_lfsr_data     = s_axis_tdata;

      unique case (r_state)
         ST_PAYLOAD: begin
            w_tready = w_load;
            if (w_load && s_axis_tvalid) begin
               w_m_tdata_next  = s_axis_tdata;
               w_m_tvalid_next = 1'b1;
               w_m_tlast_next  = 1'b0;
               w_m_tuser_next  = 1'b0;
               w_crc_next      = w_crc_out;
               w_first_next    = 1'b0;
               w_count_next    = w_count_sat;
               if (s_axis_tlast) begin
                  w_user_next    = s_axis_tuser;
                  w_fcs_idx_next = 2'd0;
                  w_state_next   = (ENABLE_PADDING && (w_count_plus1 < MIN_LEN)) ? ST_PAD : ST_FCS;
               end
            end
         end
         ST_PAD: begin
            w_lfsr_data = 8'h00;
            if (w_load) begin
               w_m_tdata_next  = 8'h00;
               w_m_tvalid_next = 1'b1;
               w_m_tlast_next  = 1'b0;
               w_m_tuser_next  = 1'b0;
               w_crc_next      = w_crc_out;
               w_count_next    = w_count_plus1[7:0];
               if (w_count_plus1 >= MIN_LEN) begin
                  w_fcs_idx_next = 2'd0;
                  w_state_next   = ST_FCS;
               end
            end
         end
         ST_FCS: begin
            if (w_load) begin
               w_m_tdata_next  = w_fcs_byte;
               w_m_tvalid_next = 1'b1;
               w_m_tlast_next  = (r_fcs_idx == 2'd3);
               w_m_tuser_next  = (r_fcs_idx == 2'd3) && r_user;
               w_fcs_idx_next  = r_fcs_idx + 2'd1;
               if (r_fcs_idx == 2'd3) begin
                  w_state_next = ST_PAYLOAD;
                  w_count_next = 8'd0;
                  w_first_next = 1'b1;
               end
            end
         end
         default: w_state_next = ST_PAYLOAD;
      endcase
   end

   // NOTE: state registers take non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state    <= ST_PAYLOAD;
         r_crc      <= 32'hffff_ffff;
         r_count    <= 8'd0;
         r_first    <= 1'b1;
         r_user     <= 1'b0;
         r_fcs_idx  <= 2'd0;
         r_m_tdata  <= 8'h00;
         r_m_tvalid <= 1'b0;
         r_m_tlast  <= 1'b0;
         r_m_tuser  <= 1'b0;
      end else begin
         r_state    <= w_state_next;
         r_crc      <= w_crc_next;
         r_count    <= w_count_next;
         r_first    <= w_first_next;
         r_user     <= w_user_next;
         r_fcs_idx  <= w_fcs_idx_next;
         r_m_tdata  <= w_m_tdata_next;
         r_m_tvalid <= w_m_tvalid_next;
         r_m_tlast  <= w_m_tlast_next;
         r_m_tuser  <= w_m_tuser_next;
      end
   end

   // Outputs read zero for the whole cycle rst is high, dropping any in-flight byte.
   assign s_axis_tready = w_tready && !rst;
   assign m_axis_tvalid = r_m_tvalid && !rst;
   assign m_axis_tdata  = rst ? 8'h00 : r_m_tdata;
   assign m_axis_tlast  = r_m_tlast && !rst;
   assign m_axis_tuser  = r_m_tuser && !rst;

endmodule

// File: tb/tb_axis_fcs_insert.sv
// Self-checking bench for axis_fcs_insert: one unpadded and one padded (MIN 60) instance,
// compared against a table-driven software CRC32 frame model.

module tb_axis_fcs_insert;

   typedef logic [7:0] u8;
   typedef struct {
      u8    data;
      logic last;
      logic user;
      int   cyc;
   } beat_t;

   localparam int MIN_LEN = 60;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst        = 1'b1;
   u8    s_tdata    = 8'h00;
   logic s_tvalid   = 1'b0;
   logic s_tlast    = 1'b0;
   logic s_tuser    = 1'b0;
   logic m_tready   = 1'b1;
   bit   sel        = 1'b0;
   bit   rand_ready = 1'b0;

   logic s_tvalid_np, s_tvalid_p;
   logic tready_np, tready_p;
   u8    md_np, md_p;
   logic mv_np, mv_p, ml_np, ml_p, mu_np, mu_p;

   assign s_tvalid_np = s_tvalid && !sel;
   assign s_tvalid_p  = s_tvalid && sel;

   axis_fcs_insert #(.ENABLE_PADDING(1'b0), .MIN_FRAME_LENGTH(MIN_LEN)) dut_nopad (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid_np), .s_axis_tready(tready_np),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(md_np), .m_axis_tvalid(mv_np), .m_axis_tready(m_tready),
      .m_axis_tlast(ml_np), .m_axis_tuser(mu_np)
   );

   axis_fcs_insert #(.ENABLE_PADDING(1'b1), .MIN_FRAME_LENGTH(MIN_LEN)) dut_pad (
      .clk(clk), .rst(rst),
      .s_axis_tdata(s_tdata), .s_axis_tvalid(s_tvalid_p), .s_axis_tready(tready_p),
      .s_axis_tlast(s_tlast), .s_axis_tuser(s_tuser),
      .m_axis_tdata(md_p), .m_axis_tvalid(mv_p), .m_axis_tready(m_tready),
      .m_axis_tlast(ml_p), .m_axis_tuser(mu_p)
   );

   wire  s_rdy = sel ? tready_p : tready_np;
   wire  mv    = sel ? mv_p : mv_np;
   wire  ml    = sel ? ml_p : ml_np;
   wire  mu    = sel ? mu_p : mu_np;
   wire  [7:0] md = sel ? md_p : md_np;

   int          n_checks = 0;
   int          n_errors = 0;
   int          cyc = 0;
   int          stall_errs = 0;
   int          accept_cyc[$];
   beat_t       out_q[$];
   beat_t       exp_q[$];
   logic [31:0] crc_tab[256];
   u8           vec[$];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      m_tready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Output monitor: records every handshake and counts changes made while stalled.
   logic pstall = 1'b0;
   u8    pd;
   logic pl;
   always @(negedge clk) begin
      if (rst) begin
         pstall = 1'b0;
      end else begin
         if (pstall && (mv !== 1'b1 || md !== pd || ml !== pl)) stall_errs++;
         if (mv && m_tready) out_q.push_back('{md, ml, mu, cyc});
         pstall = mv && !m_tready;
         pd     = md;
         pl     = ml;
      end
   end

   initial begin
      #800000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog");
   end

   function automatic void build_crc_table();
      for (int i = 0; i < 256; i++) begin
         logic [31:0] c;
         c = 32'(i);
         for (int b = 0; b < 8; b++) c = c[0] ? ((c >> 1) ^ 32'hedb8_8320) : (c >> 1);
         crc_tab[i] = c;
      end
   endfunction

   // Reference: payload, zero pad up to MIN_LEN when padding, then ~CRC32 LSB first.
   function automatic void model_frame(input u8 data[$], input bit pad, input bit user);
      u8           f[$];
      u8           idx;
      logic [31:0] crc;
      f   = data;
      crc = 32'hffff_ffff;
      if (pad) while (f.size() < MIN_LEN) f.push_back(8'h00);
      foreach (f[i]) begin
         idx = crc[7:0] ^ f[i];
         crc = crc_tab[idx] ^ (crc >> 8);
         exp_q.push_back('{f[i], 1'b0, 1'b0, 0});
      end
      crc = ~crc;
      for (int k = 0; k < 4; k++) exp_q.push_back('{crc[8*k +: 8], k == 3, (k == 3) && user, 0});
   endfunction

   function automatic void rand_bytes(input int n, output u8 q[$]);
      q.delete();
      for (int i = 0; i < n; i++) q.push_back(8'($urandom));
   endfunction

   task automatic drive_frame(input u8 data[$], input bit last_on_end, input bit user);
      int budget;
      bit ok;
      for (int i = 0; i < data.size(); i++) begin
         s_tvalid = 1'b1;
         s_tdata  = data[i];
         s_tlast  = last_on_end && (i == data.size() - 1);
         s_tuser  = user;
         budget   = 200;
         ok       = 1'b0;
         while (!ok && budget > 0) begin
            @(negedge clk);
            ok = s_rdy;
            if (ok) accept_cyc.push_back(cyc);
            @(posedge clk);
            #1;
            budget--;
         end
         if (!ok) begin
            n_checks++;
            n_errors++;
            $display("FAIL input_handshake: s_axis_tready stayed 0 for 200 cycles, required 1");
            return;
         end
      end
   endtask

   task automatic idle_in();
      s_tvalid = 1'b0;
      s_tlast  = 1'b0;
      s_tuser  = 1'b0;
   endtask

   task automatic wait_out(input int n);
      int budget;
      budget = 4000;
      while (out_q.size() < n && budget > 0) begin
         @(posedge clk);
         #1;
         budget--;
      end
      repeat (6) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_reset();
      idle_in();
      rst = 1'b1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_q.delete();
      exp_q.delete();
      accept_cyc.delete();
      stall_errs = 0;
   endtask

   task automatic test_reset();
      sel = 1'b0;
      rst = 1'b1;
      idle_in();
      @(negedge clk);
      n_checks++;
      if ({mv, md, ml, mu, s_rdy} !== 12'h000) begin
         n_errors++;
         $display("FAIL reset_outputs: got tvalid=%b tdata=%h tlast=%b tuser=%b tready=%b, required all 0",
                  mv, md, ml, mu, s_rdy);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      @(negedge clk);
      n_checks++;
      if (s_rdy !== 1'b1) begin
         n_errors++;
         $display("FAIL reset_release_tready: got %b, required 1", s_rdy);
      end
      n_checks++;
      if (mv !== 1'b0) begin
         n_errors++;
         $display("FAIL reset_release_tvalid: got %b, required 0", mv);
      end
      @(posedge clk);
      #1;
   endtask

   task automatic test_crc_vector();
      u8 fcs_ref[4];
      fcs_ref = '{8'h26, 8'h39, 8'hf4, 8'hcb};
      sel = 1'b0;
      rand_ready = 1'b0;
      do_reset();
      model_frame(vec, 1'b0, 1'b0);
      drive_frame(vec, 1'b1, 1'b0);
      idle_in();
      wait_out(13);
      n_checks++;
      if (out_q.size() !== 13) begin
         n_errors++;
         $display("FAIL crc_vec_len: got %0d beats, required 13", out_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         n_checks++;
         if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last || out_q[i].user !== exp_q[i].user) begin
            n_errors++;
            $display("FAIL crc_vec_beat%0d: got %h/%b/%b, required %h/%b/%b", i, out_q[i].data, out_q[i].last,
                     out_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
         end
      end
      for (int k = 0; k < 4 && 9 + k < out_q.size(); k++) begin
         n_checks++;
         if (out_q[9+k].data !== fcs_ref[k]) begin
            n_errors++;
            $display("FAIL crc_vec_fcs%0d: got %h, required %h", k, out_q[9+k].data, fcs_ref[k]);
         end
      end
      if (out_q.size() > 0 && accept_cyc.size() > 0) begin
         n_checks++;
         if (out_q[0].cyc !== accept_cyc[0] + 1) begin
            n_errors++;
            $display("FAIL crc_vec_latency: first output at cycle %0d, required %0d", out_q[0].cyc, accept_cyc[0] + 1);
         end
      end
      for (int i = 1; i < out_q.size(); i++) begin
         n_checks++;
         if (out_q[i].cyc !== out_q[0].cyc + i) begin
            n_errors++;
            $display("FAIL crc_vec_gap%0d: beat at cycle %0d, required %0d", i, out_q[i].cyc, out_q[0].cyc + i);
         end
      end
   endtask

   task automatic test_padding();
      u8 one[$];
      one = '{8'h00};
      sel = 1'b1;
      rand_ready = 1'b0;
      do_reset();
      model_frame(one, 1'b1, 1'b0);
      drive_frame(one, 1'b1, 1'b0);
      idle_in();
      wait_out(64);
      n_checks++;
      if (out_q.size() !== 64) begin
         n_errors++;
         $display("FAIL pad_len: got %0d beats, required 64", out_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         n_checks++;
         if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last || out_q[i].user !== exp_q[i].user) begin
            n_errors++;
            $display("FAIL pad_beat%0d: got %h/%b/%b, required %h/%b/%b", i, out_q[i].data, out_q[i].last,
                     out_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
         end
      end
      if (out_q.size() > 0) begin
         n_checks++;
         if (out_q[out_q.size()-1].cyc !== out_q[0].cyc + out_q.size() - 1) begin
            n_errors++;
            $display("FAIL pad_gaps: last beat at cycle %0d, required %0d", out_q[out_q.size()-1].cyc,
                     out_q[0].cyc + out_q.size() - 1);
         end
      end
   endtask

   task automatic test_backpressure();
      sel = 1'b0;
      rand_ready = 1'b1;
      do_reset();
      model_frame(vec, 1'b0, 1'b0);
      drive_frame(vec, 1'b1, 1'b0);
      idle_in();
      wait_out(13);
      n_checks++;
      if (out_q.size() !== 13) begin
         n_errors++;
         $display("FAIL bp_len: got %0d beats, required 13", out_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         n_checks++;
         if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last) begin
            n_errors++;
            $display("FAIL bp_beat%0d: got %h/%b, required %h/%b", i, out_q[i].data, out_q[i].last,
                     exp_q[i].data, exp_q[i].last);
         end
      end
      n_checks++;
      if (stall_errs !== 0) begin
         n_errors++;
         $display("FAIL bp_stable: %0d output changes while stalled, required 0", stall_errs);
      end
      rand_ready = 1'b0;
   endtask

   task automatic test_back_to_back();
      u8 f1[$];
      u8 f2[$];
      sel = 1'b1;
      rand_ready = 1'b0;
      do_reset();
      rand_bytes(64, f1);
      rand_bytes(64, f2);
      model_frame(f1, 1'b1, 1'b0);
      model_frame(f2, 1'b1, 1'b0);
      drive_frame(f1, 1'b1, 1'b0);
      drive_frame(f2, 1'b1, 1'b0);
      idle_in();
      wait_out(136);
      n_checks++;
      if (out_q.size() !== 136) begin
         n_errors++;
         $display("FAIL b2b_len: got %0d beats, required 136", out_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         n_checks++;
         if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last || out_q[i].cyc !== out_q[0].cyc + i) begin
            n_errors++;
            $display("FAIL b2b_beat%0d: got %h/%b at cycle %0d, required %h/%b at cycle %0d", i, out_q[i].data,
                     out_q[i].last, out_q[i].cyc, exp_q[i].data, exp_q[i].last, out_q[0].cyc + i);
         end
      end
   endtask

   task automatic test_tuser();
      u8 f[$];
      sel = 1'b0;
      rand_ready = 1'b0;
      do_reset();
      rand_bytes(20, f);
      model_frame(f, 1'b0, 1'b1);
      drive_frame(f, 1'b1, 1'b1);
      idle_in();
      wait_out(24);
      n_checks++;
      if (out_q.size() !== 24) begin
         n_errors++;
         $display("FAIL tuser_len: got %0d beats, required 24", out_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         n_checks++;
         if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last || out_q[i].user !== exp_q[i].user) begin
            n_errors++;
            $display("FAIL tuser_beat%0d: got %h/%b/%b, required %h/%b/%b", i, out_q[i].data, out_q[i].last,
                     out_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
         end
      end
   endtask

   task automatic test_mid_reset();
      u8 part[$];
      sel = 1'b0;
      rand_ready = 1'b0;
      do_reset();
      rand_bytes(5, part);
      drive_frame(part, 1'b0, 1'b0);
      idle_in();
      rst = 1'b1;
      @(negedge clk);
      n_checks++;
      if (mv !== 1'b0) begin
         n_errors++;
         $display("FAIL midrst_tvalid: got %b in reset cycle, required 0", mv);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      out_q.delete();
      exp_q.delete();
      model_frame(vec, 1'b0, 1'b0);
      drive_frame(vec, 1'b1, 1'b0);
      idle_in();
      wait_out(13);
      n_checks++;
      if (out_q.size() !== 13) begin
         n_errors++;
         $display("FAIL midrst_len: got %0d beats, required 13", out_q.size());
      end
      for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
         n_checks++;
         if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last) begin
            n_errors++;
            $display("FAIL midrst_beat%0d: got %h/%b, required %h/%b", i, out_q[i].data, out_q[i].last,
                     exp_q[i].data, exp_q[i].last);
         end
      end
   endtask

   task automatic test_random();
      int pad_lens[5];
      int np_lens[5];
      int len;
      bit user;
      u8  f[$];
      pad_lens = '{1, 59, 60, 61, 300};
      np_lens  = '{1, 2, 59, 255, 300};
      rand_ready = 1'b1;
      for (int pass = 0; pass < 2; pass++) begin
         sel = (pass == 0);
         do_reset();
         for (int j = 0; j < 6; j++) begin
            len  = (j < 5) ? (sel ? pad_lens[j] : np_lens[j]) : int'($urandom_range(1, 120));
            user = 1'($urandom_range(0, 1));
            rand_bytes(len, f);
            out_q.delete();
            exp_q.delete();
            stall_errs = 0;
            model_frame(f, sel, user);
            drive_frame(f, 1'b1, user);
            idle_in();
            wait_out(exp_q.size());
            n_checks++;
            if (out_q.size() !== exp_q.size()) begin
               n_errors++;
               $display("FAIL rand_len pad=%0b len=%0d: got %0d beats, required %0d", sel, len, out_q.size(),
                        exp_q.size());
            end
            for (int i = 0; i < exp_q.size() && i < out_q.size(); i++) begin
               n_checks++;
               if (out_q[i].data !== exp_q[i].data || out_q[i].last !== exp_q[i].last || out_q[i].user !== exp_q[i].user) begin
                  n_errors++;
                  $display("FAIL rand_beat pad=%0b len=%0d beat%0d: got %h/%b/%b, required %h/%b/%b", sel, len, i,
                           out_q[i].data, out_q[i].last, out_q[i].user, exp_q[i].data, exp_q[i].last, exp_q[i].user);
               end
            end
            n_checks++;
            if (stall_errs !== 0) begin
               n_errors++;
               $display("FAIL rand_stable pad=%0b len=%0d: %0d changes while stalled, required 0", sel, len, stall_errs);
            end
         end
      end
      rand_ready = 1'b0;
   endtask

   initial begin
      build_crc_table();
      for (int i = 0; i < 9; i++) vec.push_back(8'(8'h31 + i));
      @(posedge clk);
      #1;
      test_reset();
      test_crc_vector();
      test_padding();
      test_backpressure();
      test_back_to_back();
      test_tuser();
      test_mid_reset();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/axis_fcs_insert.md
# axis_fcs_insert

AXI-stream Ethernet FCS inserter that sequences a single combinational `lfsr` instance, configured as CRC32 (Galois, 8-bit, bit-reversed), over an 8-bit frame stream. It owns the CRC state register, feeds each accepted payload byte and each generated pad byte through the LFSR, and appends the inverted 4-byte FCS after the last byte. It sits between the MAC TX framing logic and the byte-wide GMII/encoder path.

## Interface
- `ENABLE_PADDING`, default 1: pad short frames with 0x00 before the FCS.
- `MIN_FRAME_LENGTH`, default 60: minimum payload+pad length in bytes, excluding FCS. Legal range 1..255.
- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `s_axis_tdata`  in  8  payload byte.
- `s_axis_tvalid`  in  1  input byte valid.
- `s_axis_tready`  out  1  input byte accepted when high together with `tvalid`.
- `s_axis_tlast`  in  1  last payload byte of the frame.
- `s_axis_tuser`  in  1  frame error flag, sampled on `tlast`.
- `m_axis_tdata`  out  8  output byte.
- `m_axis_tvalid`  out  1  output byte valid.
- `m_axis_tready`  in  1  downstream ready.
- `m_axis_tlast`  out  1  last FCS byte.
- `m_axis_tuser`  out  1  error flag, asserted only with `m_axis_tlast`.

## Operation
- LFSR instance: LFSR_WIDTH 32, POLY 32'h04c11db7, GALOIS, REVERSE 1, DATA_WIDTH 8, FEED_FORWARD 0. `state_in` is the CRC register; `data_in` is the byte being emitted.
- `load` = `!m_axis_tvalid || m_axis_tready`. This is the output-slot-free condition. The output register and CRC update only on `load` cycles.
- States:
  - PAYLOAD (reset state): `s_axis_tready = load`. On each accepted byte, the output register gets {byte, last=0, user=0}. CRC is updated from `state_out`. The length counter increments, saturating at MIN_FRAME_LENGTH. The first byte of a frame uses 32'hffffffff as `state_in`, not the register value.
  - On accepted `tlast`, latch `tuser` and go to:
    - PAD if ENABLE_PADDING and count+1 < MIN_FRAME_LENGTH;
    - else FCS with index 0.
  - PAD: `s_axis_tready=0`. On each `load`, emit 0x00, fold it into the CRC, and increment the count. When the count reaches MIN_FRAME_LENGTH, go to FCS.
  - FCS: `s_axis_tready=0`. On each `load`, emit byte k (k=0..3) of `~crc`, least-significant byte first; the CRC is not updated. At k=3, assert `tlast` and set `tuser` to the latched flag. Then return to PAYLOAD, with the counter cleared and the "first byte" flag set.
- `m_axis_tvalid` rises on any `load` cycle that loads a byte. It falls when `m_axis_tready` is high and no new byte is loaded.
- `tuser` never suppresses the FCS. The FCS is computed normally.

## Timing
- Reset values:
  - Outputs: `m_axis_tvalid`, `m_axis_tdata`, `m_axis_tlast`, `m_axis_tuser`, `s_axis_tready` are all 0 in the reset cycle.
  - Internal: state PAYLOAD, CRC 32'hffffffff, count 0.
  - `s_axis_tready` is 1 in the first cycle after reset is released.
- Latency: an input byte appears on `m_axis` 1 cycle after acceptance.
- Throughput: with `m_axis_tready` held high, 1 byte/cycle with no bubbles.
  - An N-byte frame (no pad) occupies N+4 output cycles.
  - The next frame's first byte is accepted in the cycle after the last FCS byte is loaded.
- Backpressure: while `m_axis_tvalid && !m_axis_tready`, all registers hold. `m_axis_t*` stays stable (AXI rule).
- Boundaries:
  - A 1-byte frame with padding enabled emits MIN_FRAME_LENGTH-1 pad bytes.
  - A frame of length ≥ MIN_FRAME_LENGTH has no pad.
  - The counter saturates, so frames of any length are legal.
- Reset mid-frame: the in-flight output byte is dropped and `m_axis_tvalid` is 0 in the reset cycle. The partial frame is never terminated. The next accepted byte starts a new frame.

## Test plan
- ASCII "123456789" (0x31..0x39, tlast on 0x39), ENABLE_PADDING=0, tready=1:
  - output is the 9 bytes then 26 39 F4 CB, with tlast only on CB;
  - 13 consecutive valid cycles, first output 1 cycle after first input.
- Single byte 0x00 with tlast, ENABLE_PADDING=1, MIN_FRAME_LENGTH=60:
  - output is 60 bytes of 0x00 then 4 FCS bytes matching a software CRC32 of 60 zero bytes;
  - 64 output beats.
- Same "123456789" frame with `m_axis_tready` randomly toggled (50%):
  - byte sequence identical to the first test;
  - `m_axis_tdata`, `tvalid`, and `tlast` never change while stalled.
- Two back-to-back 64-byte frames, tready=1:
  - 136 output beats with no idle cycle;
  - each frame's FCS is independent (the second frame's CRC seeded with ffffffff).
- Frame with `s_axis_tuser=1` on tlast:
  - `m_axis_tuser=1` only on the final FCS beat;
  - FCS value unchanged versus the same frame with tuser=0.
- `rst` asserted for 1 cycle after the 5th byte of a frame:
  - `m_axis_tvalid=0` in the reset cycle;
  - a following "123456789" frame produces exactly the first test's output.
